cp0_timer: RTL and testbench
============================

# cp0_timer

Coprocessor-0 for the pipelined MIPS core with a parametrised hardware-interrupt count, an integrated Count/Compare timer and a BadVAddr register. It sits beside the M stage, takes exception and interrupt requests from the pipeline, and redirects fetch to the handler via `int_req` and `epc`. It is the drop-in successor of the existing CP0, with the same register numbering for SR (12), Cause (13), EPC (14) and PRId (15), plus Count (9), Compare (11) and BadVAddr (8).

## Interface
- `NUM_HWINT`, default 5: number of external interrupt lines, legal range 1..5. Line i maps to Cause.IP[10+i].
- `EPC_RESET`, default 32'h0000_3000: reset value of EPC.
- `PRID_VALUE`, default 32'h0000_0000: constant returned for PRId.
- `TIMER_EN`, default 1: 0 ties the timer interrupt (IP[15]) to 0. Count still runs.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `a`  in  5  CP0 register number for mfc0/mtc0.
- `din`  in  32  mtc0 write data.
- `we`  in  1  mtc0 write enable.
- `pc`  in  32  PC of the victim instruction (M stage).
- `bd`  in  1  victim is in a branch delay slot.
- `exc_valid`  in  1  synchronous exception present in M.
- `exc_code`  in  5  ExcCode of that exception.
- `bad_vaddr`  in  32  faulting address for AdEL/AdES.
- `hw_int`  in  NUM_HWINT  level-sensitive external interrupt lines.
- `eret`  in  1  eret in M.
- `int_req`  out  1  take exception/interrupt this cycle (combinational).
- `epc`  out  32  current EPC.
- `dout`  out  32  mfc0 read data (combinational).
- `timer_irq`  out  1  timer pending bit (= Cause.IP[15]).

## Operation
- IP vector: IP[10+i] = hw_int[i] (live). IP[15] = timer pending. Unused IP bits are 0.
- `int_pend` = |(IP & SR.IM[15:10]) & SR.IE & ~SR.EXL.
- `int_req` = int_pend | exc_valid. Exceptions are taken regardless of EXL.
- When `int_req` is high, the following updates happen on that edge:
  - SR.EXL <= 1.
  - EPC <= {pc[31:2],2'b0} - (bd ? 4 : 0).
  - Cause.BD (bit 31) <= bd.
  - Cause.ExcCode[6:2] <= int_pend ? 0 : exc_code. Interrupt wins over a simultaneous exception.
  - BadVAddr <= bad_vaddr only if the exception path is selected and exc_code is 4 or 5.
- mtc0 (`we`) is ignored in any cycle where `int_req` is high.
- Writable fields:
  - SR: only IM[15:10], EXL[1] and IE[0]; all other bits read 0.
  - EPC: all 32 bits.
  - Count: all 32 bits.
  - Compare: all 32 bits.
  - Cause, PRId and BadVAddr are read-only; writes to them are dropped.
- `eret` clears EXL on the edge. If `int_req` is high in the same cycle, EXL is set (`int_req` wins).
- Cause.IP[14:10] is registered from `hw_int` every cycle and is visible to mfc0 one cycle later.
- Timer:
  - Count increments by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
  - An mtc0 to Count loads `din` and replaces that cycle's increment.
  - If Count == Compare and TIMER_EN = 1, the timer pending bit sets on the next edge. It is sticky.
  - Pending clears only on an mtc0 to Compare. If a set and a clear coincide, the clear wins.
- `dout`: selected register for a in {8,9,11,12,13,14,15}; 0 otherwise.

## Timing
- Reset values (edge with reset=0):
  - SR = 0, Cause = 0, EPC = EPC_RESET, Count = 0, Compare = 32'hFFFF_FFFF, BadVAddr = 0.
  - Resulting outputs: timer_irq = 0, epc = EPC_RESET, and int_req = exc_valid, because interrupts are masked by SR = 0.
- Reset overrides every concurrent event (int_req, mtc0, eret, timer match).
- `int_req` and `dout` are combinational, with zero latency.
- All register effects of mtc0 and exceptions appear at the next rising edge. mfc0 in the following cycle sees the new value.
- The timer interrupt asserts 1 cycle after the Count == Compare match. `int_req` follows in the same cycle if the interrupt is unmasked.

## Test plan
- Reset, then read all registers:
  - SR = 0, Cause = 0, EPC = 0x3000, Count = 0, Compare = 0xFFFFFFFF.
  - `dout` = 0 for a = 0.
  - 5 cycles later Count = 5.
- Interrupt path: SR <= 0x0000_0C01, then raise hw_int[0] with pc = 0x3010 and bd = 1.
  - int_req = 1 the same cycle.
  - Next cycle: EPC = 0x300C, Cause = 0x8000_0400 | ExcCode 0, SR.EXL = 1, int_req = 0.
  - eret, then int_req = 1 again.
- Simultaneous interrupt and exc_valid (exc_code = 4, bad_vaddr = 0x1234):
  - ExcCode = 0 and BadVAddr unchanged.
  - Repeat with the interrupt masked: ExcCode = 4, BadVAddr = 0x1234.
- Timer: Compare <= 10, Count <= 0, SR <= 0x0000_8001.
  - timer_irq = 1 and int_req = 1 after Count reaches 10.
  - timer_irq stays high through Count = 11.
  - Writing Compare clears it.
- Count wrap and priority:
  - Count <= 0xFFFF_FFFE reads 0xFFFF_FFFF, then 0.
  - mtc0 to SR in an int_req cycle is dropped.
  - eret + exc_valid in the same cycle leaves EXL = 1.
- Reset mid-operation: assert reset with EXL = 1 and timer pending.
  - Next cycle all registers hold their reset values and timer_irq = 0.
- Repeat the interrupt-path scenario with NUM_HWINT = 1 and TIMER_EN = 0.

Source files
------------

// File: rtl/cp0_timer.sv
// CP0 with Count/Compare timer and BadVAddr; int_req/dout are combinational, register effects land on the next edge.
// No backpressure: the pipeline must honour int_req in the cycle it is raised.
module cp0_timer #(
  parameter int          NUM_HWINT  = 5,
  parameter logic [31:0] EPC_RESET  = 32'h0000_3000,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000,
  parameter bit          TIMER_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           a,
  input  logic [31:0]          din,
  input  logic                 we,
  input  logic [31:0]          pc,
  input  logic                 bd,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 int_req,
  output logic [31:0]          epc,
  output logic [31:0]          dout,
  output logic                 timer_irq
);

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_SR       = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;
  localparam logic [4:0] R_PRID     = 5'd15;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [4:0]  cause_ip_hw;
  logic [4:0]  cause_exc;
  logic        timer_pend;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] badvaddr_q;

  logic [4:0]  hw_live;
  logic [5:0]  ip_vec;
  logic        int_pend;
  logic        wr_ok;
  logic        wr_sr;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic        timer_match;
  logic        exc_is_addr;
  logic [31:0] epc_next;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Pad the external lines to the full five-bit IP[14:10] field.
  always_comb begin
    hw_live = '0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      hw_live[i] = hw_int[i];
    end
  end

  assign ip_vec      = {timer_pend, hw_live};
  assign int_pend    = (|(ip_vec & sr_im)) & sr_ie & ~sr_exl;
  assign int_req     = int_pend | exc_valid;

  // An mtc0 colliding with an exception/interrupt is discarded.
  assign wr_ok       = we & ~int_req;
  assign wr_sr       = wr_ok && (a == R_SR);
  assign wr_epc      = wr_ok && (a == R_EPC);
  assign wr_count    = wr_ok && (a == R_COUNT);
  assign wr_compare  = wr_ok && (a == R_COMPARE);

  assign timer_match = TIMER_EN && (count_q == compare_q);
  assign exc_is_addr = (exc_code == 5'd4) || (exc_code == 5'd5);
  assign epc_next    = {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im  <= '0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (int_req) begin
      sr_exl <= 1'b1;
    end else begin
      if (eret) begin
        sr_exl <= 1'b0;
      end
      if (wr_sr) begin
        sr_im  <= din[15:10];
        sr_exl <= din[1];
        sr_ie  <= din[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cause_bd    <= 1'b0;
      cause_ip_hw <= '0;
      cause_exc   <= '0;
    end else begin
      cause_ip_hw <= hw_live;
      if (int_req) begin
        cause_bd  <= bd;
        cause_exc <= int_pend ? 5'd0 : exc_code;
      end
    end
  end

  // Sticky pending bit; a Compare write in the same cycle as a match clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_pend <= 1'b0;
    end else if (wr_compare) begin
      timer_pend <= 1'b0;
    end else if (timer_match) begin
      timer_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_q <= EPC_RESET;
    end else if (int_req) begin
      epc_q <= epc_next;
    end else if (wr_epc) begin
      epc_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= din;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      compare_q <= 32'hFFFF_FFFF;
    end else if (wr_compare) begin
      compare_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      badvaddr_q <= '0;
    end else if (int_req && !int_pend && exc_is_addr) begin
      badvaddr_q <= bad_vaddr;
    end
  end

  assign sr_word    = {16'h0000, sr_im, 8'h00, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'h0000, timer_pend, cause_ip_hw, 3'b000, cause_exc, 2'b00};

  always_comb begin
    dout = 32'h0000_0000;
    case (a)
      R_BADVADDR: dout = badvaddr_q;
      R_COUNT:    dout = count_q;
      R_COMPARE:  dout = compare_q;
      R_SR:       dout = sr_word;
      R_CAUSE:    dout = cause_word;
      R_EPC:      dout = epc_q;
      R_PRID:     dout = PRID_VALUE;
      default:    dout = 32'h0000_0000;
    endcase
  end

  assign epc       = epc_q;
  assign timer_irq = timer_pend;

endmodule

// File: tb/tb_cp0_timer.sv
// Directed + randomized bench for cp0_timer against a register-file level reference model.
module tb_cp0_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic [4:0]  hw_int;
  logic [0:0]  hw_int1;
  logic        eret;

  logic        int_req, timer_irq;
  logic [31:0] epc, dout;
  logic        int_req1, timer_irq1;
  logic [31:0] epc1, dout1;

  always #20 clk = ~clk;

  cp0_timer dut (
    .clk(clk), .reset(reset), .a(a), .din(din), .we(we), .pc(pc), .bd(bd),
    .exc_valid(exc_valid), .exc_code(exc_code), .bad_vaddr(bad_vaddr),
    .hw_int(hw_int), .eret(eret), .int_req(int_req), .epc(epc), .dout(dout),
    .timer_irq(timer_irq)
  );

  cp0_timer #(.NUM_HWINT(1), .TIMER_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .a(a), .din(din), .we(we), .pc(pc), .bd(bd),
    .exc_valid(exc_valid), .exc_code(exc_code), .bad_vaddr(bad_vaddr),
    .hw_int(hw_int1), .eret(eret), .int_req(int_req1), .epc(epc1), .dout(dout1),
    .timer_irq(timer_irq1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: CP0 registers by number; Cause holds only BD/ExcCode,
  // its IP bits are assembled from mhw and mpend on read.
  logic [31:0] mreg [0:15];
  logic        mpend;
  logic [4:0]  mhw;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd8:    return mreg[8];
      5'd9:    return mreg[9];
      5'd11:   return mreg[11];
      5'd12:   return mreg[12];
      5'd13:   return mreg[13] | (32'(mpend) << 15) | (32'(mhw) << 10);
      5'd14:   return mreg[14];
      5'd15:   return 32'h0000_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic m_int_pend();
    logic [31:0] ip;
    ip = (32'(hw_int) << 10) | (32'(mpend) << 15);
    return ((ip & mreg[12] & 32'h0000_FC00) != 32'd0) && mreg[12][0] && !mreg[12][1];
  endfunction

  function automatic logic m_take();
    return m_int_pend() || exc_valid;
  endfunction

  task automatic m_update();
    logic ip, take, wr, match;
    logic [31:0] cnt;
    if (!reset) begin
      mreg[8] = 32'd0; mreg[9] = 32'd0; mreg[11] = 32'hFFFF_FFFF;
      mreg[12] = 32'd0; mreg[13] = 32'd0; mreg[14] = 32'h0000_3000;
      mpend = 1'b0; mhw = 5'd0;
      return;
    end
    ip    = m_int_pend();
    take  = ip || exc_valid;
    wr    = we && !take;
    match = (mreg[9] == mreg[11]);
    cnt   = (wr && a == 5'd9) ? din : mreg[9] + 32'd1;
    mpend = (wr && a == 5'd11) ? 1'b0 : (mpend | match);
    mhw   = hw_int;
    if (take) begin
      mreg[12] = mreg[12] | 32'd2;
      mreg[14] = (pc & ~32'd3) - (bd ? 32'd4 : 32'd0);
      mreg[13] = (32'(bd) << 31) | (32'(ip ? 5'd0 : exc_code) << 2);
      if (!ip && (exc_code == 5'd4 || exc_code == 5'd5)) mreg[8] = bad_vaddr;
    end else begin
      if (eret) mreg[12] = mreg[12] & ~32'd2;
      if (wr && a == 5'd12) mreg[12] = din & 32'h0000_FC03;
      if (wr && a == 5'd14) mreg[14] = din;
      if (wr && a == 5'd11) mreg[11] = din;
    end
    mreg[9] = cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Check outputs against the model, then clock once and advance the model.
  task automatic step(input string tag);
    #1;
    chk({tag, ".dout"}, dout, m_read(a));
    chk1({tag, ".int_req"}, int_req, m_take());
    chk({tag, ".epc"}, epc, mreg[14]);
    chk1({tag, ".timer_irq"}, timer_irq, mpend);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; eret = 1'b0; exc_valid = 1'b0; bd = 1'b0;
    pc = 32'd0; exc_code = 5'd0; bad_vaddr = 32'd0; din = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] v);
    a = r; din = v; we = 1'b1;
    step("mtc0");
    we = 1'b0;
  endtask

  task automatic check_reset_regs(input string tag);
    a = 5'd8;  #1 chk({tag, ".badvaddr"}, dout, 32'd0);
    a = 5'd9;  #1 chk({tag, ".count"},    dout, 32'd0);
    a = 5'd11; #1 chk({tag, ".compare"},  dout, 32'hFFFF_FFFF);
    a = 5'd12; #1 chk({tag, ".sr"},       dout, 32'd0);
    a = 5'd13; #1 chk({tag, ".cause"},    dout, 32'd0);
    a = 5'd14; #1 chk({tag, ".epc_reg"},  dout, 32'h0000_3000);
    a = 5'd15; #1 chk({tag, ".prid"},     dout, 32'd0);
    a = 5'd0;  #1 chk({tag, ".a0"},       dout, 32'd0);
    chk({tag, ".epc"}, epc, 32'h0000_3000);
    chk1({tag, ".timer_irq"}, timer_irq, 1'b0);
    chk1({tag, ".timer_irq1"}, timer_irq1, 1'b0);
  endtask

  logic [4:0] regs [0:6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  initial begin
    reset = 1'b0; a = 5'd0; hw_int = 5'd0; hw_int1 = 1'b0;
    idle();
    @(posedge clk); m_update(); @(negedge clk);

    // Reset state, and int_req follows exc_valid even under reset
    check_reset_regs("rst");
    exc_valid = 1'b1;
    #1 chk1("rst.int_req_exc", int_req, 1'b1);
    step("rst_exc");
    exc_valid = 1'b0;
    reset = 1'b1;
    repeat (5) step("cnt");
    a = 5'd9; #1 chk("count5", dout, 32'd5);

    // Interrupt path from a delay slot
    mtc0(5'd12, 32'h0000_0C01);
    hw_int = 5'b00001; pc = 32'h0000_3010; bd = 1'b1;
    #1 chk1("irq.req", int_req, 1'b1);
    step("irq");
    pc = 32'd0; bd = 1'b0;
    #1 chk("irq.epc", epc, 32'h0000_300C);
    chk1("irq.masked", int_req, 1'b0);
    a = 5'd13; #1 chk("irq.cause", dout, 32'h8000_0400);
    a = 5'd12; #1 chk("irq.sr", dout, 32'h0000_0C03);
    eret = 1'b1; step("eret");
    eret = 1'b0;
    #1 chk1("eret.req", int_req, 1'b1);
    hw_int = 5'd0; step("drop");

    // Interrupt and address exception together, then exception alone
    hw_int = 5'b00001; exc_valid = 1'b1; exc_code = 5'd4; bad_vaddr = 32'h0000_1234;
    step("both");
    idle(); hw_int = 5'd0;
    a = 5'd13; #1 chk("both.cause", dout, 32'h0000_0400);
    a = 5'd8;  #1 chk("both.bva", dout, 32'd0);
    eret = 1'b1; step("eret2"); eret = 1'b0;
    mtc0(5'd12, 32'h0000_0001);
    hw_int = 5'b00001; exc_valid = 1'b1; exc_code = 5'd4; bad_vaddr = 32'h0000_1234;
    step("exc");
    idle(); hw_int = 5'd0;
    a = 5'd13; #1 chk("exc.cause", dout, 32'h0000_0410);
    a = 5'd8;  #1 chk("exc.bva", dout, 32'h0000_1234);
    eret = 1'b1; step("eret3"); eret = 1'b0;

    // Timer match, sticky pending, clear by Compare write
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    a = 5'd9;
    repeat (9) step("tmr");
    #1 chk("tmr.cnt10", dout, 32'd10);
    chk1("tmr.pre", timer_irq, 1'b0);
    step("tmr_match");
    chk("tmr.cnt11", dout, 32'd11);
    chk1("tmr.irq", timer_irq, 1'b1);
    chk1("tmr.req", int_req, 1'b1);
    step("tmr_take");
    chk1("tmr.sticky", timer_irq, 1'b1);
    chk1("tmr.exl", int_req, 1'b0);
    mtc0(5'd11, 32'h0000_0100);
    #1 chk1("tmr.clear", timer_irq, 1'b0);
    eret = 1'b1; step("eret4"); eret = 1'b0;

    // Count wrap, dropped mtc0, eret against exception
    mtc0(5'd9, 32'hFFFF_FFFE);
    a = 5'd9; #1 chk("wrap.fe", dout, 32'hFFFF_FFFE);
    step("wrap1"); chk("wrap.ff", dout, 32'hFFFF_FFFF);
    step("wrap2"); chk("wrap.0", dout, 32'd0);
    a = 5'd12; din = 32'h0000_FC03; we = 1'b1; exc_valid = 1'b1; exc_code = 5'd12;
    step("drop_mtc0");
    we = 1'b0; exc_valid = 1'b0;
    #1 chk("drop.sr", dout, 32'h0000_8003);
    eret = 1'b1; exc_valid = 1'b1;
    step("eret_exc");
    eret = 1'b0; exc_valid = 1'b0;
    #1 chk("eret_exc.sr", dout, 32'h0000_8003);
    eret = 1'b1; step("eret5"); eret = 1'b0;

    // Reset with EXL set and timer pending, plus colliding events
    a = 5'd11; din = mreg[9] + 32'd3; we = 1'b1;
    step("arm");
    we = 1'b0;
    repeat (4) step("wait");
    a = 5'd12; #1 chk("pre_rst.sr", dout, 32'h0000_8003);
    chk1("pre_rst.irq", timer_irq, 1'b1);
    reset = 1'b0; we = 1'b1; a = 5'd12; din = 32'h0000_FC03; exc_valid = 1'b1; eret = 1'b1;
    step("mid_rst");
    idle(); reset = 1'b1;
    check_reset_regs("mid_rst");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      reset = ($urandom_range(0, 99) != 0);
      r = $urandom_range(0, 9);
      a = (r < 7) ? regs[r] : 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 3) == 0);
      din = $urandom;
      if (a == 5'd11 && $urandom_range(0, 1) == 1) din = mreg[9] + 32'($urandom_range(0, 6));
      pc = $urandom;
      bd = 1'($urandom_range(0, 1));
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom_range(0, 7));
      bad_vaddr = $urandom;
      eret = ($urandom_range(0, 9) == 0);
      if (eret) we = 1'b0;
      if ($urandom_range(0, 7) == 0) hw_int = 5'($urandom);
      step("rnd");
    end
    idle(); hw_int = 5'd0; reset = 1'b1;

    // Single interrupt line, timer disabled
    reset = 1'b0; step("rst1"); reset = 1'b1;
    mtc0(5'd12, 32'h0000_0C01);
    hw_int1 = 1'b1; pc = 32'h0000_3010; bd = 1'b1;
    #1 chk1("n1.req", int_req1, 1'b1);
    step("n1_irq");
    pc = 32'd0; bd = 1'b0;
    #1 chk("n1.epc", epc1, 32'h0000_300C);
    chk1("n1.masked", int_req1, 1'b0);
    a = 5'd13; #1 chk("n1.cause", dout1, 32'h8000_0400);
    a = 5'd12; #1 chk("n1.sr", dout1, 32'h0000_0C03);
    eret = 1'b1; step("n1_eret"); eret = 1'b0;
    #1 chk1("n1.req2", int_req1, 1'b1);
    hw_int1 = 1'b0; step("n1_drop");
    mtc0(5'd12, 32'h0000_8001);
    a = 5'd11; din = mreg[9] + 32'd2; we = 1'b1;
    step("n1_arm");
    we = 1'b0; a = 5'd13;
    for (int i = 0; i < 5; i++) begin
      step("n1_tmr");
      chk1("n1.timer_off", timer_irq1, 1'b0);
      chk1("n1.no_req", int_req1, 1'b0);
    end
    chk("n1.ip15", dout1 & 32'h0000_8000, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
